// File: rtl/sdram_cmd_fsm.sv
// SDRAM command sequencer: arbitrates refresh/write/read in idle and walks ACT, READ/WRITE, PRE
// and AREF through fixed-latency waits. Every wait is timed by one shared cycle counter.
module sdram_cmd_fsm #(
    parameter int TRCD         = 2,
    parameter int CL           = 3,
    parameter int TWR          = 2,
    parameter int TRP          = 2,
    parameter int TRFC         = 7,
    parameter int BURST_LEN    = 4,
    parameter int REF_INTERVAL = 780
) (
    input  logic        clk_100m,
    input  logic        rst,
    input  logic        init_done,
    input  logic        wr_req,
    input  logic        rd_req,
    input  logic [23:0] sys_addr,
    output logic        wr_ack,
    output logic        rd_ack,
    output logic [3:0]  work_state,
    output logic [3:0]  sdram_cmd,
    output logic [1:0]  sdram_ba,
    output logic [12:0] sdram_addr,
    output logic        busy
);

    localparam logic [3:0] W_IDLE   = 4'd0;
    localparam logic [3:0] W_ACTIVE = 4'd1;
    localparam logic [3:0] W_TRCD   = 4'd2;
    localparam logic [3:0] W_READ   = 4'd3;
    localparam logic [3:0] W_CL     = 4'd4;
    localparam logic [3:0] W_RD     = 4'd5;
    localparam logic [3:0] W_WRITE  = 4'd6;
    localparam logic [3:0] W_WD     = 4'd7;
    localparam logic [3:0] W_TWR    = 4'd8;
    localparam logic [3:0] W_PRE    = 4'd9;
    localparam logic [3:0] W_TRP    = 4'd10;
    localparam logic [3:0] W_AR     = 4'd11;
    localparam logic [3:0] W_TRFC   = 4'd12;

    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_AREF  = 4'b0001;

    // Last cycle-counter value of each multi-cycle state (TRCD, CL, TRP, TRFC, BURST_LEN >= 2).
    localparam logic [7:0] L_TRCD = 8'(TRCD - 2);
    localparam logic [7:0] L_WD   = 8'(BURST_LEN - 2);
    localparam logic [7:0] L_TWR  = 8'(TWR - 1);
    localparam logic [7:0] L_CL   = 8'(CL - 2);
    localparam logic [7:0] L_RD   = 8'(BURST_LEN - 1);
    localparam logic [7:0] L_TRP  = 8'(TRP - 2);
    localparam logic [7:0] L_TRFC = 8'(TRFC - 2);

    localparam int             RW       = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
    localparam logic [RW-1:0]  REF_LAST = RW'(REF_INTERVAL - 1);

    logic [3:0]    state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [RW-1:0] ref_cnt_q, ref_cnt_d;
    logic          ref_pend_q, ref_pend_d;
    logic [23:0]   lat_q, lat_d;
    logic          is_wr_q, is_wr_d;
    logic          wr_ack_q, wr_ack_d;
    logic          rd_ack_q, rd_ack_d;
    logic [3:0]    cmd_q, cmd_d;
    logic [1:0]    ba_q, ba_d;
    logic [12:0]   addr_q, addr_d;

    // Handshake: wr_req/rd_req are levels the requester holds until it sees the matching ack,
    // a one-cycle pulse registered on the accepting edge; requests are only sampled in W_IDLE.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 8'd1;
        ref_cnt_d  = ref_cnt_q;
        ref_pend_d = ref_pend_q;
        lat_d      = lat_q;
        is_wr_d    = is_wr_q;
        wr_ack_d   = 1'b0;
        rd_ack_d   = 1'b0;
        cmd_d      = CMD_NOP;
        ba_d       = ba_q;
        addr_d     = addr_q;

        // Interval restarts once the refresh is issued and completed, giving 780 + 8 cycle spacing.
        if (!init_done) begin
            ref_cnt_d = '0;
        end else if (!ref_pend_q && state_q != W_AR && state_q != W_TRFC) begin
            if (ref_cnt_q == REF_LAST) begin
                ref_cnt_d  = '0;
                ref_pend_d = 1'b1;
            end else begin
                ref_cnt_d = ref_cnt_q + RW'(1);
            end
        end

        case (state_q)
            W_IDLE: begin
                if (init_done) begin
                    if (ref_pend_q) begin
                        state_d = W_AR;
                    end else if (wr_req) begin
                        state_d  = W_ACTIVE;
                        lat_d    = sys_addr;
                        is_wr_d  = 1'b1;
                        wr_ack_d = 1'b1;
                    end else if (rd_req) begin
                        state_d  = W_ACTIVE;
                        lat_d    = sys_addr;
                        is_wr_d  = 1'b0;
                        rd_ack_d = 1'b1;
                    end
                end
            end
            W_ACTIVE: state_d = W_TRCD;
            W_TRCD:   if (cnt_q == L_TRCD) state_d = is_wr_q ? W_WRITE : W_READ;
            W_WRITE:  state_d = W_WD;
            W_WD:     if (cnt_q == L_WD) state_d = W_TWR;
            W_TWR:    if (cnt_q == L_TWR) state_d = W_PRE;
            W_READ:   state_d = W_CL;
            W_CL:     if (cnt_q == L_CL) state_d = W_RD;
            W_RD:     if (cnt_q == L_RD) state_d = W_PRE;
            W_PRE:    state_d = W_TRP;
            W_TRP:    if (cnt_q == L_TRP) state_d = W_IDLE;
            W_AR:     state_d = W_TRFC;
            W_TRFC:   if (cnt_q == L_TRFC) state_d = W_IDLE;
            default:  state_d = W_IDLE;
        endcase

        if (state_d != state_q) cnt_d = 8'd0;
        if (state_d == W_AR && state_q != W_AR) ref_pend_d = 1'b0;

        // Command and address are registered against the next state so they line up with work_state.
        case (state_d)
            W_ACTIVE: begin
                cmd_d  = CMD_ACT;
                ba_d   = lat_d[23:22];
                addr_d = lat_d[21:9];
            end
            W_READ: begin
                cmd_d  = CMD_READ;
                ba_d   = lat_d[23:22];
                addr_d = {4'b0000, lat_d[8:0]};
            end
            W_WRITE: begin
                cmd_d  = CMD_WRITE;
                ba_d   = lat_d[23:22];
                addr_d = {4'b0000, lat_d[8:0]};
            end
            W_PRE: begin
                cmd_d  = CMD_PRE;
                addr_d = 13'h0400;
            end
            W_AR:    cmd_d = CMD_AREF;
            default: cmd_d = CMD_NOP;
        endcase
    end

    always_ff @(posedge clk_100m) begin
        if (rst) begin
            state_q    <= W_IDLE;
            cnt_q      <= 8'd0;
            ref_cnt_q  <= '0;
            ref_pend_q <= 1'b0;
            lat_q      <= 24'd0;
            is_wr_q    <= 1'b0;
            wr_ack_q   <= 1'b0;
            rd_ack_q   <= 1'b0;
            cmd_q      <= CMD_NOP;
            ba_q       <= 2'd0;
            addr_q     <= 13'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ref_cnt_q  <= ref_cnt_d;
            ref_pend_q <= ref_pend_d;
            lat_q      <= lat_d;
            is_wr_q    <= is_wr_d;
            wr_ack_q   <= wr_ack_d;
            rd_ack_q   <= rd_ack_d;
            cmd_q      <= cmd_d;
            ba_q       <= ba_d;
            addr_q     <= addr_d;
        end
    end

    assign work_state = state_q;
    assign busy       = (state_q != W_IDLE);
    assign sdram_cmd  = cmd_q;
    assign sdram_ba   = ba_q;
    assign sdram_addr = addr_q;
    assign wr_ack     = wr_ack_q;
    assign rd_ack     = rd_ack_q;

endmodule

// File: tb/tb_sdram_cmd_fsm.sv
// Directed bench for sdram_cmd_fsm: reset, pre-init, write, read, reset mid-read,
// refresh spacing and refresh/write/read collision ordering, all at default parameters.
module tb_sdram_cmd_fsm;

    localparam logic [3:0] NOP  = 4'b0111;
    localparam logic [3:0] ACT  = 4'b0011;
    localparam logic [3:0] RD   = 4'b0101;
    localparam logic [3:0] WR   = 4'b0100;
    localparam logic [3:0] PRE  = 4'b0010;
    localparam logic [3:0] AREF = 4'b0001;

    // sys_addr 24'hC0_1234: bank = bits[23:22] = 2'b11, row = bits[21:9] = 13'h0009, col = 9'h034
    localparam logic [23:0] ADDR = 24'hC0_1234;
    localparam logic [12:0] ROW  = 13'h0009;
    localparam logic [12:0] COLA = 13'h0034;

    logic        clk_100m = 1'b0;
    logic        rst = 1'b1;
    logic        init_done = 1'b0;
    logic        wr_req = 1'b0;
    logic        rd_req = 1'b0;
    logic [23:0] sys_addr = 24'd0;
    logic        wr_ack, rd_ack, busy;
    logic [3:0]  work_state, sdram_cmd;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_addr;

    int n_cmp  = 0;
    int n_fail = 0;

    sdram_cmd_fsm dut (
        .clk_100m   (clk_100m),
        .rst        (rst),
        .init_done  (init_done),
        .wr_req     (wr_req),
        .rd_req     (rd_req),
        .sys_addr   (sys_addr),
        .wr_ack     (wr_ack),
        .rd_ack     (rd_ack),
        .work_state (work_state),
        .sdram_cmd  (sdram_cmd),
        .sdram_ba   (sdram_ba),
        .sdram_addr (sdram_addr),
        .busy       (busy)
    );

    always #5 clk_100m = ~clk_100m;

    task automatic tick();
        @(posedge clk_100m);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock, then state/cmd/acks/busy for a cycle in which no ack is expected.
    task automatic step_chk(input string tag, input logic [3:0] st, input logic [3:0] cmd);
        tick();
        chk({tag, " state"}, 16'(work_state), 16'(st));
        chk({tag, " cmd"}, 16'(sdram_cmd), 16'(cmd));
        chk({tag, " acks"}, 16'({wr_ack, rd_ack}), 16'd0);
        chk({tag, " busy"}, 16'(busy), 16'(st != 4'd0));
    endtask

    task automatic accept_chk(input string tag, input logic is_wr);
        tick();
        chk({tag, " state"}, 16'(work_state), 16'd1);
        chk({tag, " cmd"}, 16'(sdram_cmd), 16'(ACT));
        chk({tag, " wr_ack"}, 16'(wr_ack), 16'(is_wr));
        chk({tag, " rd_ack"}, 16'(rd_ack), 16'(!is_wr));
        chk({tag, " ba"}, 16'(sdram_ba), 16'd3);
        chk({tag, " row"}, 16'(sdram_addr), 16'(ROW));
        chk({tag, " busy"}, 16'(busy), 16'd1);
    endtask

    task automatic write_path(input string tag);
        step_chk({tag, " trcd"}, 4'd2, NOP);
        step_chk({tag, " write"}, 4'd6, WR);
        chk({tag, " write ba"}, 16'(sdram_ba), 16'd3);
        chk({tag, " write col"}, 16'(sdram_addr), 16'(COLA));
        for (int i = 0; i < 3; i++) step_chk({tag, " wd"}, 4'd7, NOP);
        chk({tag, " wd addr hold"}, 16'(sdram_addr), 16'(COLA));
        for (int i = 0; i < 2; i++) step_chk({tag, " twr"}, 4'd8, NOP);
        step_chk({tag, " pre"}, 4'd9, PRE);
        chk({tag, " pre a10"}, 16'(sdram_addr[10]), 16'd1);
        step_chk({tag, " trp"}, 4'd10, NOP);
        step_chk({tag, " idle"}, 4'd0, NOP);
    endtask

    task automatic read_path(input string tag);
        step_chk({tag, " trcd"}, 4'd2, NOP);
        step_chk({tag, " read"}, 4'd3, RD);
        chk({tag, " read ba"}, 16'(sdram_ba), 16'd3);
        chk({tag, " read col"}, 16'(sdram_addr), 16'(COLA));
        for (int i = 0; i < 2; i++) step_chk({tag, " cl"}, 4'd4, NOP);
        for (int i = 0; i < 4; i++) step_chk({tag, " rd"}, 4'd5, NOP);
        step_chk({tag, " pre"}, 4'd9, PRE);
        chk({tag, " pre a10"}, 16'(sdram_addr[10]), 16'd1);
        step_chk({tag, " trp"}, 4'd10, NOP);
        step_chk({tag, " idle"}, 4'd0, NOP);
    endtask

    task automatic refresh_path(input string tag);
        step_chk({tag, " ar"}, 4'd11, AREF);
        for (int i = 0; i < 6; i++) step_chk({tag, " trfc"}, 4'd12, NOP);
        step_chk({tag, " idle"}, 4'd0, NOP);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " state"}, 16'(work_state), 16'd0);
        chk({tag, " cmd"}, 16'(sdram_cmd), 16'(NOP));
        chk({tag, " ba"}, 16'(sdram_ba), 16'd0);
        chk({tag, " addr"}, 16'(sdram_addr), 16'd0);
        chk({tag, " acks"}, 16'({wr_ack, rd_ack}), 16'd0);
        chk({tag, " busy"}, 16'(busy), 16'd0);
    endtask

    initial begin
        // Reset
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;

        // Pre-init: requests ignored, no refresh
        wr_req = 1'b1;
        for (int i = 0; i < 100; i++) step_chk("preinit", 4'd0, NOP);
        wr_req = 1'b0;

        // Write (first edge with init_done=1 accepts)
        init_done = 1'b1;
        sys_addr  = ADDR;
        wr_req    = 1'b1;
        accept_chk("wr accept", 1'b1);
        wr_req = 1'b0;
        write_path("wr");

        // Read
        rd_req = 1'b1;
        accept_chk("rd accept", 1'b0);
        rd_req = 1'b0;
        read_path("rd");

        // Reset during the second W_RD cycle
        rd_req = 1'b1;
        accept_chk("rst rd accept", 1'b0);
        rd_req = 1'b0;
        step_chk("rst trcd", 4'd2, NOP);
        step_chk("rst read", 4'd3, RD);
        for (int i = 0; i < 2; i++) step_chk("rst cl", 4'd4, NOP);
        for (int i = 0; i < 2; i++) step_chk("rst rd", 4'd5, NOP);
        rst = 1'b1;
        tick();
        check_reset_outputs("midread rst");
        rst = 1'b0;
        step_chk("after rst no pre", 4'd0, NOP);

        // Refresh counter restarted at the edge above; wrap on the 779th following edge
        for (int i = 1; i <= 779; i++) step_chk("ref wait", 4'd0, NOP);

        // Collision: ref_pending set, both requests raised
        wr_req = 1'b1;
        rd_req = 1'b1;
        refresh_path("coll ref");
        accept_chk("coll wr accept", 1'b1);
        wr_req = 1'b0;
        write_path("coll wr");
        accept_chk("coll rd accept", 1'b0);
        rd_req = 1'b0;
        read_path("coll rd");

        // Next AREF lands 788 cycles after the previous one
        for (int i = 811; i <= 1567; i++) begin
            tick();
            chk("ref gap no aref", 16'(sdram_cmd == AREF), 16'd0);
        end
        refresh_path("ref period");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
